sw_debounce_io: RTL and testbench

- Input-conditioning stage directly upstream of the data-memory/IO block.
- Takes the raw board switches, synchronises each bit to clk and debounces it independently, then drives the clean value onto the memory/IO block's `sw` input.
- Also produces per-bit edge pulses, a one-cycle change strobe and a sticky change flag, so the processor can detect switch activity by polling.

---
 rtl/sw_debounce_io.sv | 75 +++++++
 tb/tb_sw_debounce_io.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sw_debounce_io.sv
// Switch input conditioning: two-flop synchroniser and independent per-bit debounce,
// with registered edge pulses, a change strobe and a sticky change flag for polling.
module sw_debounce_io #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             evt_clr,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             sw_event
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            r_s1;
    logic [WIDTH-1:0]            r_s2;
    logic [WIDTH-1:0]            r_stable;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_rise;
    logic [WIDTH-1:0]            r_fall;
    logic                        r_changed;
    logic                        r_event;

    logic [WIDTH-1:0]            w_diff;
    logic [WIDTH-1:0]            w_accept;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_next;

    // The counter runs only while the synchronised bit disagrees with the stable
    // value; agreeing again (a glitch or bounce) or acceptance returns it to zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_diff[gi]     = r_s2[gi] ^ r_stable[gi];
            assign w_accept[gi]   = w_diff[gi] && (r_cnt[gi] == CNT_MAX);
            assign w_cnt_next[gi] = (!w_diff[gi] || w_accept[gi]) ? '0
                                  : r_cnt[gi] + CNT_W'(1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_stable  <= '0;
            r_cnt     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            r_event   <= 1'b0;
        end else begin
            r_s1      <= sw_raw;
            r_s2      <= r_s1;
            r_stable  <= r_stable ^ w_accept;
            r_cnt     <= w_cnt_next;
            r_rise    <= w_accept & r_s2;
            r_fall    <= w_accept & ~r_s2;
            r_changed <= |w_accept;
            // A change strobe in the same cycle as a clear keeps the flag set.
            r_event   <= r_changed | (r_event & ~evt_clr);
        end
    end

    assign sw         = r_stable;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_changed;
    assign sw_event   = r_event;

endmodule

// File: tb/tb_sw_debounce_io.sv
// Self-checking bench for sw_debounce_io with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_sw_debounce_io;

    typedef struct packed {
        logic [7:0] raw;
        logic       clr;
        logic [7:0] sw;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
        logic       evt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_raw;
    logic       evt_clr;
    logic [7:0] sw;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_changed;
    logic       sw_event;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t sb[$];
    vec_t tbl[25];

    sw_debounce_io #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .evt_clr(evt_clr),
        .sw(sw),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed),
        .sw_event(sw_event)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] raw, input logic clr,
                                input logic [7:0] esw, input logic [7:0] erise,
                                input logic [7:0] efall, input logic echg, input logic eevt);
        vec_t v;
        v.raw = raw; v.clr = clr; v.sw = esw; v.rise = erise;
        v.fall = efall; v.chg = echg; v.evt = eevt;
        return v;
    endfunction

    task automatic compare(input string name);
        vec_t e;
        e = sb.pop_front();
        n_tests++;
        if (sw !== e.sw || sw_rise !== e.rise || sw_fall !== e.fall ||
            sw_changed !== e.chg || sw_event !== e.evt) begin
            n_fail++;
            $display("FAIL %s: got sw=%h rise=%h fall=%h chg=%b evt=%b, want sw=%h rise=%h fall=%h chg=%b evt=%b",
                     name, sw, sw_rise, sw_fall, sw_changed, sw_event,
                     e.sw, e.rise, e.fall, e.chg, e.evt);
        end else begin
            $display("[TB] %s: sw=%h rise=%h fall=%h chg=%b evt=%b ok",
                     name, sw, sw_rise, sw_fall, sw_changed, sw_event);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs seen after that edge.
    task automatic step(input vec_t v, input string name);
        sw_raw  = v.raw;
        evt_clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        compare(name);
    endtask

    initial begin
        rst_n   = 1'b0;
        sw_raw  = 8'hFF;
        evt_clr = 1'b0;

        // Reset release with all switches high, return to zero, sticky clear, glitch reject.
        for (int i = 0; i < 5; i++)   tbl[i] = mk(8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        tbl[5] = mk(8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 1, 0);
        tbl[6] = mk(8'hFF, 0, 8'hFF, 8'h00, 8'h00, 0, 1);
        tbl[7] = mk(8'hFF, 0, 8'hFF, 8'h00, 8'h00, 0, 1);
        for (int i = 8; i < 13; i++)  tbl[i] = mk(8'h00, 0, 8'hFF, 8'h00, 8'h00, 0, 1);
        tbl[13] = mk(8'h00, 0, 8'h00, 8'h00, 8'hFF, 1, 1);
        tbl[14] = mk(8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 1);
        tbl[15] = mk(8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 0);
        tbl[16] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        for (int i = 17; i < 20; i++) tbl[i] = mk(8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        for (int i = 20; i < 25; i++) tbl[i] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.push_back(mk(8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        compare("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) step(tbl[i], $sformatf("vec[%0d]", i));

        // Bounce on bit 2: acceptance 6 edges after the final rising raw edge.
        step(mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 0), "bounce1");
        step(mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0), "bounce0");
        step(mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 0), "bounce1");
        step(mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0), "bounce0");
        for (int i = 1; i < 6; i++)
            step(mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 0), $sformatf("bounce_hold%0d", i));
        step(mk(8'h04, 0, 8'h04, 8'h04, 8'h00, 1, 0), "bounce_accept");
        step(mk(8'h04, 0, 8'h04, 8'h00, 8'h00, 0, 1), "bounce_after");
        step(mk(8'h04, 1, 8'h04, 8'h00, 8'h00, 0, 0), "bounce_clr");

        // Independent bits 3 and 5 rise two cycles apart, then fall together.
        step(mk(8'h0C, 0, 8'h04, 8'h00, 8'h00, 0, 0), "indep1");
        step(mk(8'h0C, 0, 8'h04, 8'h00, 8'h00, 0, 0), "indep2");
        for (int i = 3; i < 6; i++)
            step(mk(8'h2C, 0, 8'h04, 8'h00, 8'h00, 0, 0), $sformatf("indep%0d", i));
        step(mk(8'h2C, 0, 8'h0C, 8'h08, 8'h00, 1, 0), "indep_b3");
        step(mk(8'h2C, 0, 8'h0C, 8'h00, 8'h00, 0, 1), "indep_gap");
        step(mk(8'h2C, 0, 8'h2C, 8'h20, 8'h00, 1, 1), "indep_b5");
        step(mk(8'h2C, 0, 8'h2C, 8'h00, 8'h00, 0, 1), "indep_after");
        for (int i = 1; i < 6; i++)
            step(mk(8'h04, 0, 8'h2C, 8'h00, 8'h00, 0, 1), $sformatf("fall_wait%0d", i));
        step(mk(8'h04, 0, 8'h04, 8'h00, 8'h28, 1, 1), "fall_both");
        step(mk(8'h04, 0, 8'h04, 8'h00, 8'h00, 0, 1), "fall_after");
        step(mk(8'h04, 1, 8'h04, 8'h00, 8'h00, 0, 0), "fall_clr");

        // Asynchronous reset mid-count, then the full latency restarts.
        for (int i = 1; i < 4; i++)
            step(mk(8'h80, 0, 8'h04, 8'h00, 8'h00, 0, 0), $sformatf("midcnt%0d", i));
        #2;
        rst_n = 1'b0;
        sb.push_back(mk(8'h80, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        #1;
        compare("async_reset");
        @(posedge clk);
        @(negedge clk);
        sb.push_back(mk(8'h80, 0, 8'h00, 8'h00, 8'h00, 0, 0));
        compare("in_reset");
        rst_n = 1'b1;
        for (int i = 1; i < 6; i++)
            step(mk(8'h80, 0, 8'h00, 8'h00, 8'h00, 0, 0), $sformatf("restart%0d", i));
        step(mk(8'h80, 0, 8'h80, 8'h80, 8'h00, 1, 0), "restart_accept");
        step(mk(8'h80, 0, 8'h80, 8'h00, 8'h00, 0, 1), "restart_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
